udp_frame_arbiter: RTL and testbench

- Frame-level round-robin arbiter that shares the udp_reader_top input FIFO between NUM_SRC Ethernet frame sources.
- Each source is a first-word-fall-through FIFO read port carrying bytes with sof/eof flags.
- The arbiter grants one source at a time and holds the grant until that source's eof byte is written downstream, so frames never interleave.
- It also truncates runaway frames, discards orphan bytes, and counts frames and dropped bytes.

---
 rtl/udp_frame_arbiter.sv | 161 ++++++++++++++++
 tb/tb_udp_frame_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : udp_frame_arbiter
// Brief    : Frame-level round-robin arbiter feeding one downstream byte FIFO
//            from NUM_SRC FWFT frame sources, with truncation and orphan drop.
// Revision : 1.0
// ============================================================================
module udp_frame_arbiter #(
    parameter int NUM_SRC         = 2,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_SRC-1:0]                              src_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]                   src_dout,
    input  logic [NUM_SRC-1:0]                              src_sof,
    input  logic [NUM_SRC-1:0]                              src_eof,
    output logic [NUM_SRC-1:0]                              src_rd_en,
    input  logic                                            out_full,
    output logic                                            out_wr_en,
    output logic [DATA_WIDTH-1:0]                           out_din,
    output logic                                            out_sof,
    output logic                                            out_eof,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] grant,
    output logic                                            busy,
    output logic [15:0]                                     frame_count,
    output logic [15:0]                                     drop_count
);

    localparam int c_GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int c_CW = $clog2(MAX_FRAME_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_GW-1:0]       r_grant;
    logic [c_GW-1:0]       r_last_grant;
    logic [c_GW-1:0]       w_sel;
    logic                  w_sel_vld;
    logic [c_CW-1:0]       r_byte_cnt;
    logic [15:0]           r_frame_count;
    logic [15:0]           r_drop_count;
    logic [DATA_WIDTH-1:0] w_dout [NUM_SRC];
    logic                  w_head_empty;
    logic                  w_head_sof;
    logic                  w_head_eof;
    logic                  w_last_slot;
    logic                  w_fire;
    logic                  w_eof;
    logic                  w_drop_pop;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
            assign w_dout[g] = src_dout[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_head_empty = src_empty[r_grant];
    assign w_head_sof   = src_sof[r_grant];
    assign w_head_eof   = src_eof[r_grant];
    assign w_last_slot  = (r_byte_cnt == c_CW'(MAX_FRAME_BYTES - 1));

    // Scan from the farthest offset down so the nearest non-empty source
    // after the previous grant is the one left in w_sel.
    always_comb begin
        int idx;
        idx       = 0;
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = (int'(r_last_grant) + i) % NUM_SRC;
            if (!src_empty[idx]) begin
                w_sel_vld = 1'b1;
                w_sel     = c_GW'(idx);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        src_rd_en  = '0;
        out_wr_en  = 1'b0;
        out_din    = w_dout[r_grant];
        out_sof    = 1'b0;
        out_eof    = 1'b0;
        w_fire     = 1'b0;
        w_eof      = w_head_eof || w_last_slot;
        w_drop_pop = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) begin
                    w_next = src_sof[w_sel] ? ST_XFER : ST_DROP;
                end
            end
            ST_XFER: begin
                w_fire             = !w_head_empty && !out_full;
                out_wr_en          = w_fire;
                src_rd_en[r_grant] = w_fire;
                out_sof            = (r_byte_cnt == '0);
                out_eof            = w_eof;
                if (w_fire && w_eof) begin
                    w_next = w_head_eof ? ST_IDLE : ST_DROP;
                end
            end
            ST_DROP: begin
                // A fresh frame start ends the discard without consuming it.
                if (!w_head_empty) begin
                    if (w_head_sof && !w_head_eof) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_drop_pop         = 1'b1;
                        src_rd_en[r_grant] = 1'b1;
                        if (w_head_eof) begin
                            w_next = ST_IDLE;
                        end
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_last_grant  <= c_GW'(NUM_SRC - 1);
            r_byte_cnt    <= '0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_sel_vld) begin
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
            end
            if (w_fire) begin
                r_byte_cnt <= w_eof ? '0 : r_byte_cnt + c_CW'(1);
                if (w_eof) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
            end
            if (w_drop_pop) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign grant       = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_udp_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_frame_arbiter
// Brief    : Self-checking bench: source FIFOs as queues, frame-level model.
// Revision : 1.0
// ============================================================================
module tb_udp_frame_arbiter;

    localparam int NS   = 2;
    localparam int DW   = 8;
    localparam int MAXB = 1518;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NS-1:0]     src_empty;
    logic [NS*DW-1:0]  src_dout;
    logic [NS-1:0]     src_sof;
    logic [NS-1:0]     src_eof;
    logic [NS-1:0]     src_rd_en;
    logic              out_full;
    logic              out_wr_en;
    logic [DW-1:0]     out_din;
    logic              out_sof;
    logic              out_eof;
    logic [0:0]        grant;
    logic              busy;
    logic [15:0]       frame_count;
    logic [15:0]       drop_count;

    udp_frame_arbiter #(
        .NUM_SRC        (NS),
        .DATA_WIDTH     (DW),
        .MAX_FRAME_BYTES(MAXB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .src_empty  (src_empty),
        .src_dout   (src_dout),
        .src_sof    (src_sof),
        .src_eof    (src_eof),
        .src_rd_en  (src_rd_en),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .out_din    (out_din),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .grant      (grant),
        .busy       (busy),
        .frame_count(frame_count),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    // Queue entry {sof, eof, data}; stream entry {src, sof, eof, data}.
    logic [9:0]  srcq [NS][$];
    logic [10:0] got[$];
    logic [10:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc, first_wr, last_wr, full_mode, viol;
    int exp_frames, exp_drops;

    typedef struct {
        int o0; int len0; int nfr0; int extra0;
        int o1; int len1; int nfr1;
        int full_mode;
        int exp_frames; int exp_drops; int exp_writes;
        int exp_first; int exp_last;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic add_orphans(input int k, input int n);
        for (int i = 0; i < n; i++) srcq[k].push_back({2'b00, 8'($urandom)});
    endtask

    task automatic add_frame(input int k, input int len, input bit mid_sof);
        logic s, e;
        for (int i = 0; i < len; i++) begin
            s = (i == 0) || (mid_sof && len > 2 && i == len / 2);
            e = (i == len - 1);
            srcq[k].push_back({s, e, 8'($urandom)});
        end
    endtask

    function automatic bit all_empty();
        bit r = 1'b1;
        for (int k = 0; k < NS; k++) if (srcq[k].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drive();
        logic [9:0] h;
        for (int k = 0; k < NS; k++) begin
            if (srcq[k].size() > 0) begin
                h = srcq[k][0];
                src_empty[k]         = 1'b0;
                src_sof[k]           = h[9];
                src_eof[k]           = h[8];
                src_dout[k*DW +: DW] = h[7:0];
            end else begin
                src_empty[k]         = 1'b1;
                src_sof[k]           = 1'b0;
                src_eof[k]           = 1'b0;
                src_dout[k*DW +: DW] = 8'($urandom);
            end
        end
        case (full_mode)
            1:       out_full = ((cyc / 3) % 2) == 1;
            2:       out_full = ($urandom_range(0, 9) < 3);
            default: out_full = 1'b0;
        endcase
    endtask

    task automatic cycle();
        @(negedge clock);
        drive();
        #1;
        if (out_wr_en && out_full) viol++;
        if (out_wr_en && !src_rd_en[grant]) viol++;
        for (int k = 0; k < NS; k++) begin
            if (src_rd_en[k]) begin
                if (srcq[k].size() == 0) viol++;
                else void'(srcq[k].pop_front());
            end
        end
        if (out_wr_en) begin
            got.push_back({grant[0], out_sof, out_eof, out_din});
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        cyc++;
    endtask

    // Frame-level reference: round-robin over non-empty queues, forward a
    // frame up to MAXB bytes, discard orphans / truncation tails.
    task automatic model();
        logic [9:0] mq [NS][$];
        logic [9:0] b;
        int last, s, n, idx;
        bit drop;
        exp_q.delete();
        exp_frames = 0;
        exp_drops  = 0;
        for (int k = 0; k < NS; k++) mq[k] = srcq[k];
        last = NS - 1;
        forever begin
            s = -1;
            for (int i = 1; i <= NS; i++) begin
                idx = (last + i) % NS;
                if (s < 0 && mq[idx].size() > 0) s = idx;
            end
            if (s < 0) break;
            last = s;
            drop = 1'b1;
            b = mq[s][0];
            if (b[9]) begin
                drop = 1'b0;
                n = 0;
                while (mq[s].size() > 0) begin
                    b = mq[s].pop_front();
                    exp_q.push_back({s[0], (n == 0), (b[8] || n == MAXB - 1), b[7:0]});
                    n++;
                    if (b[8]) begin exp_frames++; break; end
                    if (n == MAXB) begin exp_frames++; drop = 1'b1; break; end
                end
            end
            if (drop) begin
                while (mq[s].size() > 0) begin
                    b = mq[s][0];
                    if (b[9] && !b[8]) break;
                    void'(mq[s].pop_front());
                    exp_drops++;
                    if (b[8]) break;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_wr_en", int'(out_wr_en), 0);
        check("rst_rd_en", int'(src_rd_en), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_drop_count", int'(drop_count), 0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic start_run(input int mode);
        model();
        got.delete();
        full_mode = mode;
        cyc       = 0;
        first_wr  = -1;
        last_wr   = -1;
        viol      = 0;
    endtask

    task automatic finish_run(input string tag);
        int mm;
        do cycle(); while (!(all_empty() && !busy) && cyc < 6000);
        check({tag, "_timeout"}, int'(cyc >= 6000), 0);
        check({tag, "_protocol_violations"}, viol, 0);
        check({tag, "_writes"}, got.size(), exp_q.size());
        mm = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (mm < 0 && got[i] != exp_q[i]) mm = i;
        check({tag, "_first_stream_diff"}, mm, -1);
        if (mm >= 0) $display("  index %0d got %h expected %h", mm, got[mm], exp_q[mm]);
        check({tag, "_frame_count"}, int'(frame_count), exp_frames);
        check({tag, "_drop_count"}, int'(drop_count), exp_drops);
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{0, 64,   1, 0,  0, 0,   0, 0, 1, 0,  64,   1, 64};
        tbl[1] = '{0, 100,  3, 0,  0, 100, 3, 0, 6, 0,  600,  1, 605};
        tbl[2] = '{0, 1024, 1, 0,  0, 0,   0, 1, 1, 0,  1024, -1, -1};
        tbl[3] = '{0, 1600, 1, 10, 0, 0,   0, 0, 2, 82, 1528, 1, 1611};
        tbl[4] = '{0, 0,    0, 0,  5, 10,  1, 0, 1, 5,  10,   8, 17};

        src_empty = '1;
        src_sof   = '0;
        src_eof   = '0;
        src_dout  = '0;
        out_full  = 1'b0;
        full_mode = 0;
        cyc       = 0;

        for (int i = 0; i < 5; i++) begin
            do_reset();
            add_orphans(0, tbl[i].o0);
            for (int f = 0; f < tbl[i].nfr0; f++) add_frame(0, tbl[i].len0, 1'b0);
            if (tbl[i].extra0 > 0) add_frame(0, tbl[i].extra0, 1'b0);
            add_orphans(1, tbl[i].o1);
            for (int f = 0; f < tbl[i].nfr1; f++) add_frame(1, tbl[i].len1, 1'b0);
            start_run(tbl[i].full_mode);
            finish_run($sformatf("vec%0d", i));
            check($sformatf("vec%0d_tbl_frames", i), int'(frame_count), tbl[i].exp_frames);
            check($sformatf("vec%0d_tbl_drops", i), int'(drop_count), tbl[i].exp_drops);
            check($sformatf("vec%0d_tbl_writes", i), got.size(), tbl[i].exp_writes);
            if (tbl[i].exp_first >= 0) begin
                check($sformatf("vec%0d_first_write_cycle", i), first_wr, tbl[i].exp_first);
                check($sformatf("vec%0d_last_write_cycle", i), last_wr, tbl[i].exp_last);
            end
        end

        // Reset in the middle of a frame, then source 0 must win first.
        do_reset();
        add_frame(0, 500, 1'b0);
        add_frame(1, 20, 1'b0);
        start_run(0);
        while (got.size() < 200 && cyc < 2000) cycle();
        check("midrst_reach_byte200", got.size(), 200);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_wr_en", int'(out_wr_en), 0);
        check("midrst_rd_en", int'(src_rd_en), 0);
        check("midrst_grant", int'(grant), 0);
        check("midrst_frame_count", int'(frame_count), 0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        start_run(0);
        cycle();
        @(posedge clock);
        #1;
        check("midrst_first_grant", int'(grant), 0);
        check("midrst_first_busy", int'(busy), 1);
        finish_run("midrst");
        check("midrst_drops", int'(drop_count), 300);

        // Randomized traffic with back-pressure, orphans and stray mid-frame sof.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < NS; k++) begin
                int nf;
                nf = $urandom_range(1, 4);
                for (int f = 0; f < nf; f++) begin
                    if ($urandom_range(0, 4) == 0) add_orphans(k, $urandom_range(1, 4));
                    add_frame(k, $urandom_range(1, 30), $urandom_range(0, 3) == 0);
                end
            end
            start_run(2);
            finish_run($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
